// File: rtl/shift_cmd_fifo_if.sv
// Command-queue bus between a producer/consumer and shift_cmd_fifo.
// Carries the push/pop requests, the queued {data, shift} pair and the status flags.
interface shift_cmd_fifo_if #(
    parameter int CW = 3
);
    logic          Wr_En;
    logic [7:0]    Din_I;
    logic [2:0]    Din_Shift;
    logic          Rd_En;
    logic          Clr_Err;
    logic [7:0]    I;
    logic [2:0]    Shift;
    logic          Valid;
    logic          Full;
    logic          Empty;
    logic [CW-1:0] Count;
    logic          Overflow;
    logic          Underflow;

    modport master (
        output Wr_En, Din_I, Din_Shift, Rd_En, Clr_Err,
        input  I, Shift, Valid, Full, Empty, Count, Overflow, Underflow
    );

    modport slave (
        input  Wr_En, Din_I, Din_Shift, Rd_En, Clr_Err,
        output I, Shift, Valid, Full, Empty, Count, Overflow, Underflow
    );
endinterface

// File: rtl/shift_cmd_fifo.sv
// Command buffer ahead of the 8-bit left shifter: queues {data, shift}
// pairs and presents one popped pair per read on registered I/Shift outputs.
// Sticky Overflow/Underflow flags record rejected pushes/pops.
module shift_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic             clk,
    input logic             rst,
    shift_cmd_fifo_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [10:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_i;
    logic [2:0]    r_shift;
    logic          r_valid;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    // Status decoded from the registered count only; push at full is allowed when a pop frees the slot.
    always_comb begin
        w_full  = (r_count == CW'(DEPTH));
        w_empty = (r_count == '0);
        w_pop   = bus.Rd_En && !w_empty;
        w_push  = bus.Wr_En && (!w_full || bus.Rd_En);
    end

    // Storage array: not reset, stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.Din_I, bus.Din_Shift};
        end
    end

    // Pointers, occupancy and the registered output pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_i      <= '0;
            r_shift  <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                {r_i, r_shift} <= r_mem[r_rd_ptr];
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Sticky error flags; a same-cycle Clr_Err wins over a new error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.Clr_Err) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.Wr_En && w_full && !bus.Rd_En) begin
                r_overflow <= 1'b1;
            end
            if (bus.Rd_En && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.I         = r_i;
    assign bus.Shift     = r_shift;
    assign bus.Valid     = r_valid;
    assign bus.Full      = w_full;
    assign bus.Empty     = w_empty;
    assign bus.Count     = r_count;
    assign bus.Overflow  = r_overflow;
    assign bus.Underflow = r_underflow;
endmodule
